// File: rtl/ifetch_if.sv
// ifetch_if: fetch request/response channel between the fetch unit (master) and its responder (slave)
interface ifetch_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_pc;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_ir;
  modport master (output req_vld, req_pc, rsp_rdy, input req_rdy, rsp_vld, rsp_ir);
  modport slave  (input req_vld, req_pc, rsp_rdy, output req_rdy, rsp_vld, rsp_ir);
endinterface

// File: rtl/ifetch_resp.sv
// ifetch_resp: serves fetch PCs from a 1-cycle-latency SRAM through an in-order response FIFO
module ifetch_resp #(
  parameter int            AW     = 32,
  parameter int            DW     = 32,
  parameter int            MAW    = 12,
  parameter int            DEPTH  = 2,
  parameter logic [DW-1:0] ILL_IR = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  ifetch_if.slave        ifetch,
  output logic           mem_ce,
  output logic [MAW-1:0] mem_addr,
  input  logic [DW-1:0]  mem_rdata,
  output logic [31:0]    fetch_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DW-1:0] fifo [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [CW:0]   occ;
  logic          inflt, inflt_bad, bad, req_hsk, rsp_hsk;
  assign rsp_hsk = ifetch.rsp_vld & ifetch.rsp_rdy;
  // Reserve a slot for the read in flight so the FIFO can never overflow
  assign occ = {1'b0, cnt} + (CW+1)'(inflt) - (CW+1)'(rsp_hsk);
  assign ifetch.req_rdy = rst_n & (occ < (CW+1)'(DEPTH));
  assign req_hsk = ifetch.req_vld & ifetch.req_rdy;
  assign bad = (|ifetch.req_pc[1:0]) | (|ifetch.req_pc[AW-1:MAW+2]);
  assign mem_ce = req_hsk & ~bad;
  assign mem_addr = mem_ce ? ifetch.req_pc[MAW+1:2] : '0;
  assign ifetch.rsp_vld = cnt != '0;
  assign ifetch.rsp_ir = fifo[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      inflt <= 1'b0;
      inflt_bad <= 1'b0;
      fetch_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      inflt <= req_hsk;
      inflt_bad <= bad;
      if (req_hsk) fetch_cnt <= fetch_cnt + 32'd1;
      if (inflt) begin
        fifo[wp] <= inflt_bad ? ILL_IR : mem_rdata;
        wp <= wp + 1'b1;
      end
      if (rsp_hsk) rp <= rp + 1'b1;
      if (inflt & ~rsp_hsk) cnt <= cnt + 1'b1;
      else if (rsp_hsk & ~inflt) cnt <= cnt - 1'b1;
    end
endmodule

// File: tb/tb_ifetch_resp.sv
// tb_ifetch_resp: directed vector table plus hand sequences for latency, backpressure, reset and random traffic
module tb_ifetch_resp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ce;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] fetch_cnt;
  logic [31:0] sram [4096];
  logic [31:0] exp_q [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          rsp_n = 0;
  int          acc_n = 0;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic [11:0] addr;
    logic [31:0] ir;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  ifetch_if #(.AW(32), .DW(32)) f ();

  ifetch_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ifetch    (f),
    .mem_ce    (mem_ce),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .fetch_cnt (fetch_cnt)
  );

  always @(posedge clk) if (mem_ce) mem_rdata <= sram[mem_addr];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] model(input logic [31:0] pc);
    return (pc[1:0] != 2'b0 || pc[31:14] != 18'b0) ? 32'h0 : sram[pc[13:2]];
  endfunction

  // Scoreboard: every response handshake must match the oldest accepted request
  always @(negedge clk)
    if (rst_n && f.rsp_vld && f.rsp_rdy) begin
      rsp_n++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_rsp: got %h expected no response", f.rsp_ir);
      end else chk("rsp_ir", f.rsp_ir, exp_q.pop_front());
    end

  task automatic drv(input logic v, input logic [31:0] pc, input logic rr);
    f.req_vld = v;
    f.req_pc = pc;
    f.rsp_rdy = rr;
    @(negedge clk);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  function automatic logic accept(input logic [31:0] ir);
    if (f.req_vld && f.req_rdy) begin
      exp_q.push_back(ir);
      acc_n++;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    int          rn, j;
    logic        a, last_rdy;
    logic [31:0] pc;
    for (int i = 0; i < 4096; i++) sram[i] = 32'hA000_0000 | i;
    sram[5] = 32'h0010_0093;
    tbl[0] = '{32'h0000_0014, 1'b1, 12'd5,     32'h0010_0093};
    tbl[1] = '{32'h0000_0006, 1'b0, 12'd0,     32'h0000_0000};
    tbl[2] = '{32'h0000_3FFC, 1'b1, 12'hFFF,   32'hA000_0FFF};
    tbl[3] = '{32'h0000_4000, 1'b0, 12'd0,     32'h0000_0000};
    tbl[4] = '{32'h0000_0008, 1'b1, 12'd2,     32'hA000_0002};
    tbl[5] = '{32'h8000_0000, 1'b0, 12'd0,     32'h0000_0000};
    tbl[6] = '{32'h0000_0001, 1'b0, 12'd0,     32'h0000_0000};
    tbl[7] = '{32'h0000_0040, 1'b1, 12'd16,    32'hA000_0010};

    drv(1'b1, 32'h14, 1'b1);
    chk("rst_rsp_vld", {31'b0, f.rsp_vld}, 32'd0);
    chk("rst_rsp_ir", f.rsp_ir, 32'd0);
    chk("rst_mem_ce", {31'b0, mem_ce}, 32'd0);
    chk("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    nxt;
    f.req_vld = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_req_rdy", {31'b0, f.req_rdy}, 32'd1);

    drv(1'b1, 32'h14, 1'b1);
    chk("single_req_rdy", {31'b0, f.req_rdy}, 32'd1);
    chk("single_mem_ce", {31'b0, mem_ce}, 32'd1);
    chk("single_mem_addr", {20'b0, mem_addr}, 32'd5);
    a = accept(32'h0010_0093);
    nxt;
    drv(1'b0, 32'h0, 1'b1);
    chk("single_vld_t1", {31'b0, f.rsp_vld}, 32'd0);
    nxt;
    drv(1'b0, 32'h0, 1'b1);
    chk("single_vld_t2", {31'b0, f.rsp_vld}, 32'd1);
    chk("single_ir_t2", f.rsp_ir, 32'h0010_0093);
    chk("single_fetch_cnt", fetch_cnt, 32'd1);
    nxt;

    for (int i = 0; i < 8; i++) begin
      drv(1'b1, tbl[i].pc, 1'b1);
      chk($sformatf("tbl%0d_req_rdy", i), {31'b0, f.req_rdy}, 32'd1);
      chk($sformatf("tbl%0d_mem_ce", i), {31'b0, mem_ce}, {31'b0, tbl[i].ce});
      chk($sformatf("tbl%0d_mem_addr", i), {20'b0, mem_addr}, {20'b0, tbl[i].addr});
      a = accept(tbl[i].ir);
      nxt;
    end
    repeat (4) begin drv(1'b0, 32'h0, 1'b1); nxt; end
    chk("tbl_drained", exp_q.size(), 32'd0);

    rn = rsp_n;
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, i * 4, 1'b1);
      chk($sformatf("stream%0d_req_rdy", i), {31'b0, f.req_rdy}, 32'd1);
      a = accept(sram[i]);
      nxt;
    end
    repeat (2) begin drv(1'b0, 32'h0, 1'b1); nxt; end
    chk("stream_back_to_back", rsp_n - rn, 32'd16);
    chk("stream_fetch_cnt", fetch_cnt, 32'd25);

    rn = rsp_n;
    j = 0;
    last_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 32'h20 + j * 4, 1'b0);
      last_rdy = f.req_rdy;
      if (accept(model(32'h20 + j * 4))) j++;
      nxt;
    end
    chk("bp_accepted", j, 32'd2);
    chk("bp_req_rdy_low", {31'b0, last_rdy}, 32'd0);
    drv(1'b1, 32'h20 + j * 4, 1'b1);
    chk("bp_pop_rsp_vld", {31'b0, f.rsp_vld}, 32'd1);
    chk("bp_pop_req_rdy", {31'b0, f.req_rdy}, 32'd1);
    a = accept(model(32'h20 + j * 4));
    nxt;
    repeat (4) begin drv(1'b0, 32'h0, 1'b1); nxt; end
    chk("bp_rsp_count", rsp_n - rn, 32'd3);
    chk("bp_drained", exp_q.size(), 32'd0);

    drv(1'b1, 32'h30, 1'b0);
    a = accept(model(32'h30));
    nxt;
    drv(1'b1, 32'h34, 1'b0);
    a = accept(model(32'h34));
    nxt;
    drv(1'b1, 32'h38, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_vld", {31'b0, f.rsp_vld}, 32'd0);
    chk("midrst_rsp_ir", f.rsp_ir, 32'd0);
    chk("midrst_mem_ce", {31'b0, mem_ce}, 32'd0);
    chk("midrst_fetch_cnt", fetch_cnt, 32'd0);
    exp_q.delete();
    acc_n = 0;
    f.req_vld = 1'b0;
    repeat (2) nxt;
    rst_n = 1'b1;
    rn = rsp_n;
    drv(1'b1, 32'h18, 1'b1);
    chk("postrst_req_rdy", {31'b0, f.req_rdy}, 32'd1);
    a = accept(sram[6]);
    nxt;
    drv(1'b0, 32'h0, 1'b1);
    chk("postrst_vld_t1", {31'b0, f.rsp_vld}, 32'd0);
    nxt;
    drv(1'b0, 32'h0, 1'b1);
    chk("postrst_vld_t2", {31'b0, f.rsp_vld}, 32'd1);
    chk("postrst_ir_t2", f.rsp_ir, 32'hA000_0006);
    nxt;
    repeat (3) begin drv(1'b0, 32'h0, 1'b1); nxt; end
    chk("postrst_rsp_count", rsp_n - rn, 32'd1);
    chk("postrst_fetch_cnt", fetch_cnt, 32'd1);

    pc = 32'h0;
    a = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (a || !f.req_vld) begin
        pc = ($urandom_range(0, 7) == 0) ? 32'h4000 + ($urandom_range(0, 3) * 2)
                                         : {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      end
      drv(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)));
      a = accept(model(pc));
      nxt;
    end
    repeat (6) begin drv(1'b0, 32'h0, 1'b1); nxt; end
    chk("rand_drained", exp_q.size(), 32'd0);
    chk("rand_fetch_cnt", fetch_cnt, acc_n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
